// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative-latency MIPS multiply/divide unit holding HI/LO.
// Define MDU_MADD_EN to enable MDOp=111 as signed multiply-accumulate (madd).
module mult_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [2:0]  MDOp,
   input  logic [31:0] SrcA,
   input  logic [31:0] SrcB,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q;
   logic [31:0] cnt_q, hi_q, lo_q, ph_q, pl_q;
   logic        busy_q, upd_q;

   logic        is_mul, is_div, sgn;
   logic [31:0] abs_a, abs_b, uq, ur, quo, rem;
   logic [63:0] smul, umul, res_d;

   // One shared magnitude divider; signed div fixes up signs afterwards,
   // which also makes 0x80000000 / -1 wrap cleanly.
   always_comb begin
      sgn   = MDOp == 3'd3;
      abs_a = (sgn && SrcA[31]) ? -SrcA : SrcA;
      abs_b = (sgn && SrcB[31]) ? -SrcB : SrcB;
      uq    = (abs_b == 32'd0) ? 32'd0 : abs_a / abs_b;
      ur    = (abs_b == 32'd0) ? 32'd0 : abs_a % abs_b;
      quo   = (sgn && (SrcA[31] ^ SrcB[31])) ? -uq : uq;
      rem   = (sgn && SrcA[31]) ? -ur : ur;
      smul  = {{32{SrcA[31]}}, SrcA} * {{32{SrcB[31]}}, SrcB};
      umul  = {32'd0, SrcA} * {32'd0, SrcB};
      is_div = (MDOp == 3'd3) || (MDOp == 3'd4);
`ifdef MDU_MADD_EN
      is_mul = (MDOp == 3'd1) || (MDOp == 3'd2) || (MDOp == 3'd7);
      res_d  = (MDOp == 3'd7) ? {hi_q, lo_q} + smul :
               (MDOp == 3'd2) ? umul :
               is_div         ? {rem, quo} : smul;
`else
      is_mul = (MDOp == 3'd1) || (MDOp == 3'd2);
      res_d  = (MDOp == 3'd2) ? umul :
               is_div         ? {rem, quo} : smul;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         ph_q    <= '0;
         pl_q    <= '0;
         busy_q  <= 1'b0;
         upd_q   <= 1'b0;
      end else if (state_q == IDLE) begin
         if (Start && (is_mul || is_div)) begin
            {ph_q, pl_q} <= res_d;
            upd_q   <= !(is_div && SrcB == 32'd0);
            cnt_q   <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= RUN;
         end else if (Start && MDOp == 3'd5) begin
            hi_q <= SrcA;
         end else if (Start && MDOp == 3'd6) begin
            lo_q <= SrcA;
         end
      end else if (cnt_q == 32'd1) begin
         if (upd_q) {hi_q, lo_q} <= {ph_q, pl_q};
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         state_q <= IDLE;
      end else begin
         cnt_q <= cnt_q - 32'd1;
      end
   end

   assign Busy = busy_q;
   assign HI   = hi_q;
   assign LO   = lo_q;
endmodule
